// File: rtl/flasher_step_sched.sv
// Step sequencer for the 16-LED bound flasher: walks the fill/drain bounce
// pattern and issues one paced set/clear command per step over valid/ready.
module flasher_step_sched #(
    parameter int N_LEDS   = 16,
    parameter int IDX_W    = 4,
    parameter int TICK_DIV = 4,
    parameter int B_HI     = 15,
    parameter int B_MID1   = 5,
    parameter int B_MID2   = 10,
    parameter int B_LO     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic             cmd_op,
    output logic [IDX_W-1:0] cmd_idx,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // The first fill never addresses past the last physical LED.
    localparam int FILL_A_END = (B_HI < N_LEDS) ? B_HI : N_LEDS - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL_A  = 3'd1,
        DRAIN_A = 3'd2,
        FILL_B  = 3'd3,
        DRAIN_B = 3'd4,
        FILL_C  = 3'd5,
        DRAIN_C = 3'd6
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               valid_q, valid_d;
    logic               op_q, op_d;
    logic [IDX_W-1:0]   cidx_q, cidx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               kick_s;

    function automatic logic [IDX_W-1:0] phase_end(input phase_t ph);
        case (ph)
            FILL_A:  phase_end = IDX_W'(FILL_A_END);
            DRAIN_A: phase_end = IDX_W'(B_MID1);
            FILL_B:  phase_end = IDX_W'(B_MID2);
            DRAIN_B: phase_end = IDX_W'(B_LO);
            FILL_C:  phase_end = IDX_W'(B_MID1);
            DRAIN_C: phase_end = IDX_W'(B_LO);
            default: phase_end = IDX_W'(B_LO);
        endcase
    endfunction

    // Fill phases set LEDs walking upward; drain phases clear walking downward.
    function automatic logic phase_up(input phase_t ph);
        case (ph)
            FILL_A, FILL_B, FILL_C: phase_up = 1'b1;
            default:                phase_up = 1'b0;
        endcase
    endfunction

    function automatic phase_t phase_next(input phase_t ph);
        case (ph)
            FILL_A:  phase_next = DRAIN_A;
            DRAIN_A: phase_next = FILL_B;
            FILL_B:  phase_next = DRAIN_B;
            DRAIN_B: phase_next = FILL_C;
            FILL_C:  phase_next = DRAIN_C;
            default: phase_next = IDLE;
        endcase
    endfunction

    // Kick-back only at drain checkpoints, and only while a command is accepted.
    always_comb begin
        kick_s = 1'b0;
        if (flick) begin
            case (phase_q)
                DRAIN_A: kick_s = (idx_q == IDX_W'(B_MID1));
                DRAIN_B: kick_s = (idx_q == IDX_W'(B_MID1)) || (idx_q == IDX_W'(B_LO));
                default: kick_s = 1'b0;
            endcase
        end else begin
            kick_s = 1'b0;
        end
    end

    // Next-state: start, tick pacing, command issue and step advance.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        valid_d = valid_q;
        op_d    = op_q;
        cidx_d  = cidx_q;
        done_d  = 1'b0;
        case (phase_q)
            IDLE: begin
                valid_d = 1'b0;
                tick_d  = '0;
                if (flick && !done_q) begin
                    phase_d = FILL_A;
                    idx_d   = IDX_W'(B_LO);
                end else begin
                    phase_d = IDLE;
                end
            end
            default: begin
                if (valid_q) begin
                    if (cmd_ready) begin
                        valid_d = 1'b0;
                        if (kick_s) begin
                            phase_d = (phase_q == DRAIN_A) ? FILL_A : FILL_B;
                        end else if (idx_q != phase_end(phase_q)) begin
                            idx_d = phase_up(phase_q) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                        end else if (phase_q == DRAIN_C) begin
                            phase_d = IDLE;
                            idx_d   = IDX_W'(B_LO);
                            done_d  = 1'b1;
                        end else begin
                            phase_d = phase_next(phase_q);
                        end
                    end else begin
                        valid_d = 1'b1;
                    end
                end else if (tick_q == TICK_LAST) begin
                    valid_d = 1'b1;
                    op_d    = phase_up(phase_q);
                    cidx_d  = idx_q;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
        endcase
        busy_d = (phase_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= IDLE;
            idx_q   <= IDX_W'(B_LO);
            tick_q  <= '0;
            valid_q <= 1'b0;
            op_q    <= 1'b0;
            cidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            cidx_q  <= cidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_op    = op_q;
    assign cmd_idx   = cidx_q;
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_flasher_step_sched.sv
// Directed bench for flasher_step_sched: full bounce, backpressure, kick-backs,
// pacing at TICK_DIV=4 and asynchronous reset.
module tb_flasher_step_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       flick, cmd_ready;
    logic       cmd_valid, cmd_op, busy, done;
    logic [3:0] cmd_idx;
    logic [2:0] phase;

    logic       flick4, ready4;
    logic       valid4, op4, busy4, done4;
    logic [3:0] idx4;
    logic [2:0] phase4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];

    always #5 clk = ~clk;

    flasher_step_sched #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .flick(flick), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .phase(phase), .busy(busy), .done(done)
    );

    flasher_step_sched #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .flick(flick4), .cmd_ready(ready4),
        .cmd_valid(valid4), .cmd_op(op4), .cmd_idx(idx4),
        .phase(phase4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_seg(input logic op, input int from, input int to);
        if (from <= to) begin
            for (int i = from; i <= to; i++) exp_q.push_back({op, i[3:0]});
        end else begin
            for (int i = from; i >= to; i--) exp_q.push_back({op, i[3:0]});
        end
    endtask

    task automatic build_std();
        exp_q.delete();
        add_seg(1'b1, 0, 15);
        add_seg(1'b0, 15, 5);
        add_seg(1'b1, 5, 10);
        add_seg(1'b0, 10, 0);
        add_seg(1'b1, 0, 5);
        add_seg(1'b0, 5, 0);
    endtask

    task automatic compare_queues(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_cmd%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Starts a sequence with one flick and records every accepted command.
    task automatic run_seq(input int bp_en, input int kick_ph, input int kick_idx,
                           input int kick_to, output int n_done);
        int  stop_at, last_acc, cyc;
        bit  bp_used, kick_used, chk_next, spacing;
        logic [4:0] held;
        got_q.delete();
        n_done = 0; stop_at = -1; last_acc = -1; cyc = 0;
        bp_used = 0; kick_used = 0; chk_next = 0;
        spacing = (bp_en == 0) && (kick_ph == 0);
        cmd_ready = 1'b1;
        flick = 1'b1;
        step();
        flick = 1'b0;
        check("start_busy", busy, 1);
        check("start_phase", phase, 1);
        check("start_no_valid", cmd_valid, 0);
        while (cyc < 800 && (stop_at < 0 || cyc < stop_at)) begin
            flick = 1'b0;
            if (chk_next) begin
                check("kick_phase", phase, kick_to);
                chk_next = 0;
            end
            if (done) begin
                n_done++;
                check("done_busy", busy, 0);
                check("done_phase", phase, 0);
                if (stop_at < 0) stop_at = cyc + 4;
            end
            if (cmd_valid) begin
                if (bp_en != 0 && !bp_used && cmd_op && cmd_idx == 4'd7 && phase == 3'd1) begin
                    bp_used = 1;
                    held = {cmd_op, cmd_idx};
                    cmd_ready = 1'b0;
                    repeat (3) begin
                        step();
                        check("bp_valid", cmd_valid, 1);
                        check("bp_cmd", 32'({cmd_op, cmd_idx}), 32'(held));
                    end
                    cmd_ready = 1'b1;
                end
                if (kick_ph != 0 && !kick_used && phase == kick_ph[2:0] && cmd_idx == kick_idx[3:0]
                    && !cmd_op) begin
                    flick = 1'b1;
                    kick_used = 1;
                    chk_next = 1;
                end
                if (spacing && last_acc >= 0) check("spacing", cyc - last_acc, 2);
                last_acc = cyc;
                got_q.push_back({cmd_op, cmd_idx});
            end
            step();
            cyc++;
        end
        flick = 1'b0;
        if (bp_en != 0) check("bp_seen", bp_used, 1);
        if (kick_ph != 0) check("kick_seen", kick_used, 1);
    endtask

    initial begin
        int nd, n, m, waitc;
        bit seen;
        rst = 1'b1; flick = 1'b0; cmd_ready = 1'b1; flick4 = 1'b0; ready4 = 1'b1;
        repeat (3) step();
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_phase", phase, 0);
        check("rst_done", done, 0);
        check("rst_op", cmd_op, 0);
        check("rst_idx", cmd_idx, 0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_valid", cmd_valid, 0);

        // Full run with ready tied high.
        run_seq(0, 0, 0, 0, nd);
        build_std();
        compare_queues("full");
        check("full_done_once", nd, 1);
        check("full_end_busy", busy, 0);

        // Backpressure on set 7.
        run_seq(1, 0, 0, 0, nd);
        build_std();
        compare_queues("bp");
        check("bp_done_once", nd, 1);

        // Kick-back in DRAIN_A at idx 5.
        run_seq(0, 2, 5, 1, nd);
        exp_q.delete();
        add_seg(1'b1, 0, 15); add_seg(1'b0, 15, 5);
        add_seg(1'b1, 5, 15); add_seg(1'b0, 15, 5);
        add_seg(1'b1, 5, 10); add_seg(1'b0, 10, 0);
        add_seg(1'b1, 0, 5);  add_seg(1'b0, 5, 0);
        compare_queues("kickA");
        check("kickA_done", nd, 1);

        // Kick-back in DRAIN_B at idx 0.
        run_seq(0, 4, 0, 3, nd);
        exp_q.delete();
        add_seg(1'b1, 0, 15); add_seg(1'b0, 15, 5);
        add_seg(1'b1, 5, 10); add_seg(1'b0, 10, 0);
        add_seg(1'b1, 0, 10); add_seg(1'b0, 10, 0);
        add_seg(1'b1, 0, 5);  add_seg(1'b0, 5, 0);
        compare_queues("kickB0");
        check("kickB0_done", nd, 1);

        // Kick-back in DRAIN_B at idx 5.
        run_seq(0, 4, 5, 3, nd);
        exp_q.delete();
        add_seg(1'b1, 0, 15); add_seg(1'b0, 15, 5);
        add_seg(1'b1, 5, 10); add_seg(1'b0, 10, 5);
        add_seg(1'b1, 5, 10); add_seg(1'b0, 10, 0);
        add_seg(1'b1, 0, 5);  add_seg(1'b0, 5, 0);
        compare_queues("kickB5");
        check("kickB5_done", nd, 1);

        // flick at clear 7 in DRAIN_B is not a checkpoint.
        run_seq(0, 4, 7, 4, nd);
        build_std();
        compare_queues("nokick");
        check("nokick_done", nd, 1);

        // Pacing on the TICK_DIV=4 instance.
        seen = 0;
        repeat (10) begin
            step();
            if (valid4) seen = 1;
        end
        check("idle_no_cmd", seen, 0);
        flick4 = 1'b1;
        step();
        flick4 = 1'b0;
        n = 0;
        while (!valid4 && n < 20) begin step(); n++; end
        check("first_latency", n, 4);
        check("first_cmd", 32'({op4, idx4}), 32'({1'b1, 4'd0}));
        for (int k = 0; k < 2; k++) begin
            step();
            m = 1;
            while (!valid4 && m < 20) begin step(); m++; end
            check("rise_spacing", m, 5);
        end
        check("second_idx_seen", idx4, 2);

        // Asynchronous reset while a FILL_B command is pending.
        cmd_ready = 1'b1;
        flick = 1'b1;
        step();
        flick = 1'b0;
        waitc = 0;
        while (!(phase == 3'd3 && cmd_valid) && waitc < 200) begin step(); waitc++; end
        cmd_ready = 1'b0;
        check("reached_fill_b", phase, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_phase", phase, 0);
        #1 rst = 1'b0;
        cmd_ready = 1'b1;
        step();
        check("post_rst_idle", busy, 0);
        flick = 1'b1;
        step();
        flick = 1'b0;
        step();
        check("restart_valid", cmd_valid, 1);
        check("restart_cmd", 32'({cmd_op, cmd_idx}), 32'({1'b1, 4'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
